// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares one register-file write port between two
// writeback requesters. Each requester has a 2-entry FIFO behind valid/ready.
// The winning head is registered onto reg_write/write_reg/write_data, and a
// pending-write mask is published for RAW hazard stalls.
// Optional feature macro: RF_ARB_ROUND_ROBIN_EN (round-robin on contention);
// when undefined, requester 0 has fixed priority.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [31:0]       pending_mask,
  output logic              busy
);

  localparam int unsigned NREQ   = 2;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned MASK_W = 32;

  logic [ADDR_W-1:0] fifo_reg  [NREQ][DEPTH];
  logic [DATA_W-1:0] fifo_data [NREQ][DEPTH];
  logic [CNT_W-1:0]  count     [NREQ];
  logic [NREQ-1:0]   rd_ptr;
  logic [NREQ-1:0]   wr_ptr;

  logic [NREQ-1:0]   in_valid;
  logic [ADDR_W-1:0] in_reg  [NREQ];
  logic [DATA_W-1:0] in_data [NREQ];
  logic [NREQ-1:0]   ready;
  logic [NREQ-1:0]   push;
  logic [NREQ-1:0]   non_empty;
  logic [NREQ-1:0]   grant;
  logic [ADDR_W-1:0] head_reg;
  logic [DATA_W-1:0] head_data;

  assign in_valid   = {req1_valid, req0_valid};
  assign in_reg[0]  = req0_reg;
  assign in_reg[1]  = req1_reg;
  assign in_data[0] = req0_data;
  assign in_data[1] = req1_data;
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

  // Ready from registered occupancy only; held low while reset is asserted
  always_comb begin
    ready     = '0;
    push      = '0;
    non_empty = '0;
    for (int r = 0; r < NREQ; r++) begin
      ready[r]     = !reset && (count[r] < CNT_W'(DEPTH));
      push[r]      = in_valid[r] && ready[r];
      non_empty[r] = (count[r] != '0);
    end
  end

`ifdef RF_ARB_ROUND_ROBIN_EN
  logic last_grant;

  // Contention goes to the requester opposite the previous grant
  always_comb begin
    grant    = '0;
    grant[0] = non_empty[0] && (!non_empty[1] || last_grant);
    grant[1] = non_empty[1] && !grant[0];
  end

  // Remember who was granted last; reset favours requester 0 first
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end
`else
  // Fixed priority: requester 0 always wins contention
  always_comb begin
    grant    = '0;
    grant[0] = non_empty[0];
    grant[1] = non_empty[1] && !non_empty[0];
  end
`endif

  // Select the granted FIFO head
  always_comb begin
    head_reg  = fifo_reg[0][rd_ptr[0]];
    head_data = fifo_data[0][rd_ptr[0]];
    if (grant[1]) begin
      head_reg  = fifo_reg[1][rd_ptr[1]];
      head_data = fifo_data[1][rd_ptr[1]];
    end
  end

  // FIFO storage, written at the tail on push
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREQ; r++) begin
      if (push[r]) begin
        fifo_reg[r][wr_ptr[r]]  <= in_reg[r];
        fifo_data[r][wr_ptr[r]] <= in_data[r];
      end
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int r = 0; r < NREQ; r++) begin
        count[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREQ; r++) begin
        if (push[r]) wr_ptr[r] <= ~wr_ptr[r];
        if (grant[r]) rd_ptr[r] <= ~rd_ptr[r];
        count[r] <= count[r] + CNT_W'(push[r]) - CNT_W'(grant[r]);
      end
    end
  end

  // Output stage: register the popped head; writes to x0 are swallowed
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else if (|grant) begin
      reg_write  <= (head_reg != '0);
      write_reg  <= head_reg;
      write_data <= head_data;
    end else begin
      reg_write  <= 1'b0;
    end
  end

  // Pending mask over valid FIFO slots and the in-flight write; bit 0 stays 0
  always_comb begin
    logic slot_valid;
    pending_mask = '0;
    slot_valid   = 1'b0;
    for (int r = 0; r < NREQ; r++) begin
      for (int s = 0; s < DEPTH; s++) begin
        slot_valid = (count[r] == CNT_W'(2)) ||
                     ((count[r] == CNT_W'(1)) && (rd_ptr[r] == 1'(s)));
        for (int i = 1; i < MASK_W; i++) begin
          if (slot_valid && (fifo_reg[r][s] == ADDR_W'(i))) pending_mask[i] = 1'b1;
        end
      end
    end
    for (int i = 1; i < MASK_W; i++) begin
      if (reg_write && (write_reg == ADDR_W'(i))) pending_mask[i] = 1'b1;
    end
  end

  assign busy = reg_write || non_empty[0] || non_empty[1];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: scoreboard of expected writes,
// checked on the falling edge whenever reg_write is observed high.
module tb_regfile_write_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [ADDR_W-1:0] req0_reg, req1_reg, write_reg;
  logic [DATA_W-1:0] req0_data, req1_data, write_data;
  logic              reg_write, busy;
  logic [31:0]       pending_mask;

  typedef struct packed {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         src0[$];
  wr_t         src1[$];
  logic        rdy1_hist[$];
  logic [31:0] rf [32];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg(req0_reg), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg(req1_reg), .req1_data(req1_data),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .pending_mask(pending_mask), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Advance to the next falling edge and score any write on the port
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (reg_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(reg_write), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("write_reg", 32'(write_reg), 32'(e.r));
        chk("write_data", write_data, e.d);
      end
      rf[write_reg] = write_data;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("ready0_in_reset", 32'(req0_ready), 32'(0));
    chk("ready1_in_reset", 32'(req1_ready), 32'(0));
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_reg_write", 32'(reg_write), 32'(0));
    chk("rst_write_reg", 32'(write_reg), 32'(0));
    chk("rst_write_data", write_data, 32'(0));
    chk("rst_pending", pending_mask, 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_ready0", 32'(req0_ready), 32'(1));
    chk("rst_ready1", 32'(req1_ready), 32'(1));
  endtask

  // Expected grant order while both requesters stay busy
  task automatic build_exp();
    int na = src0.size();
    int nb = src1.size();
`ifdef RF_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < ((na > nb) ? na : nb); i++) begin
      if (i < na) exp_q.push_back(src0[i]);
      if (i < nb) exp_q.push_back(src1[i]);
    end
`else
    for (int i = 0; i < na; i++) exp_q.push_back(src0[i]);
    for (int i = 0; i < nb; i++) exp_q.push_back(src1[i]);
`endif
  endtask

  // Hold each requester's head item valid until accepted
  task automatic run_streams(input int budget, input bit must_finish);
    int n = 0;
    bit a0, a1;
    while ((src0.size() != 0 || src1.size() != 0) && n < budget) begin
      req0_valid = (src0.size() != 0);
      if (req0_valid) begin req0_reg = src0[0].r; req0_data = src0[0].d; end
      req1_valid = (src1.size() != 0);
      if (req1_valid) begin req1_reg = src1[0].r; req1_data = src1[0].d; end
      rdy1_hist.push_back(req1_ready);
      a0 = req0_valid && (req0_ready === 1'b1);
      a1 = req1_valid && (req1_ready === 1'b1);
      tick();
      n++;
      if (a0) void'(src0.pop_front());
      if (a1) void'(src1.pop_front());
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (must_finish) chk("stream_done", 32'(src0.size() + src1.size()), 32'(0));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'(0));
    tick();
    tick();
    chk("drain_busy", 32'(busy), 32'(0));
  endtask

  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_reg = '0; req1_reg = '0; req0_data = '0; req1_data = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;

    do_reset();

    // Single write to r9: two-cycle latency, pending for two cycles
    req0_valid = 1'b1; req0_reg = 5'd9; req0_data = 32'hDEADBEEF;
    exp_q.push_back('{r: 5'd9, d: 32'hDEADBEEF});
    tick();
    req0_valid = 1'b0;
    chk("lat_t1_no_write", 32'(reg_write), 32'(0));
    chk("lat_t1_pend9", 32'(pending_mask[9]), 32'(1));
    chk("lat_t1_busy", 32'(busy), 32'(1));
    tick();
    chk("lat_t2_write", 32'(reg_write), 32'(1));
    chk("lat_t2_pend9", 32'(pending_mask[9]), 32'(1));
    tick();
    chk("lat_t3_no_write", 32'(reg_write), 32'(0));
    chk("lat_t3_pend9", 32'(pending_mask[9]), 32'(0));
    chk("rf9", rf[9], 32'hDEADBEEF);

    // Write to x0: consumed, never written, never pending
    req0_valid = 1'b1; req0_reg = 5'd0; req0_data = 32'h1234;
    tick();
    req0_valid = 1'b0;
    chk("x0_t1_mask", pending_mask, 32'(0));
    chk("x0_t1_busy", 32'(busy), 32'(1));
    tick();
    chk("x0_t2_reg_write", 32'(reg_write), 32'(0));
    chk("x0_t2_data", write_data, 32'h1234);
    chk("x0_t2_mask", pending_mask, 32'(0));
    tick();
    chk("x0_t3_mask", pending_mask, 32'(0));
    chk("x0_t3_busy", 32'(busy), 32'(0));

    // Sustained contention
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src0.push_back('{r: 5'(1 + i), d: 32'hA000_0000 + 32'(i)});
      src1.push_back('{r: 5'(16 + i), d: 32'hB000_0000 + 32'(i)});
    end
    build_exp();
    run_streams(40, 1'b1);
    drain(20);

    // Backpressure on requester 1 while requester 0 streams
    do_reset();
    rdy1_hist.delete();
    for (int i = 0; i < 6; i++) src0.push_back('{r: 5'(2 + i), d: 32'hC000_0000 + 32'(i)});
    for (int i = 0; i < 3; i++) src1.push_back('{r: 5'(20 + i), d: 32'hD000_0000 + 32'(i)});
    build_exp();
    run_streams(40, 1'b1);
    chk("bp_ready1_c0", 32'(rdy1_hist[0]), 32'(1));
    chk("bp_ready1_c1", 32'(rdy1_hist[1]), 32'(1));
    chk("bp_ready1_c2", 32'(rdy1_hist[2]), 32'(0));
    drain(20);

    // Reset mid-operation discards buffered writes
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src0.push_back('{r: 5'(1 + i), d: 32'hE000_0000 + 32'(i)});
      src1.push_back('{r: 5'(16 + i), d: 32'hF000_0000 + 32'(i)});
    end
    build_exp();
    run_streams(3, 1'b0);
    src0.delete();
    src1.delete();
    exp_q.delete();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_mask", pending_mask, 32'(0));
    end
    chk("post_rst_busy", 32'(busy), 32'(0));

    // Same destination from both requesters in one cycle
    src0.push_back('{r: 5'd5, d: 32'hA});
    src1.push_back('{r: 5'd5, d: 32'hB});
    exp_q.push_back('{r: 5'd5, d: 32'hA});
    exp_q.push_back('{r: 5'd5, d: 32'hB});
    run_streams(10, 1'b1);
    chk("same_reg_pend5", 32'(pending_mask[5]), 32'(1));
    drain(10);
    chk("rf5_final", rf[5], 32'hB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
